// File: rtl/reg_apb2native_if.sv
// reg_apb2native_if: APB completer that forwards each transfer as a single
// native register request (req_vld pulse) and waits for ack_vld.
// Optional feature: define REG_APB2NATIVE_TIMEOUT_EN to abort transfers that
// see no ack within TIMEOUT_CYCLES cycles (PSLVERR=1, PRDATA=0).
//
// Handshake: APB side accepts a setup phase (PSEL=1, PENABLE=0) only in IDLE
// and answers with a single-cycle PREADY; native side issues a one-cycle
// req_vld, holds addr/wr_en/rd_en/wr_data stable until the ack_vld cycle, and
// ack_vld is only honoured while a request is outstanding (REQ or WAIT).
module reg_apb2native_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // APB completer
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  // native initiator
  output logic                  req_vld,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ack_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  // debug view of the FSM
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Last cycle index (counting from 0 in REQ) at which an ack is still honoured.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic   is_wr_q;
  logic   busy;
  logic   accept;
  logic   tmo_hit;

  assign busy   = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign accept = (state_q == ST_IDLE) && PSEL && !PENABLE;

`ifdef REG_APB2NATIVE_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       err_q;

  // An ack in the final cycle wins over the timeout.
  assign tmo_hit = busy && !ack_vld && (tmo_cnt_q == TMO_LAST);

  // Cycle counter over REQ/WAIT plus the error flag reported with PREADY.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      if (busy && !ack_vld && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      else                              tmo_cnt_q <= 8'd0;
      if (busy && ack_vld)  err_q <= 1'b0;
      else if (tmo_hit)     err_q <= 1'b1;
    end
  end

  assign PSLVERR = (state_q == ST_RESP) && err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LAST;
  assign tmo_hit    = 1'b0;
  assign PSLVERR    = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; PSEL dropping mid-transfer does not abort the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ,
      ST_WAIT: begin
        if (ack_vld || tmo_hit) state_d = ST_RESP;
        else                    state_d = ST_WAIT;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture at setup phase and response data capture on ack/timeout.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr    <= '0;
      wr_data <= '0;
      is_wr_q <= 1'b0;
      PRDATA  <= '0;
    end else begin
      if (accept) begin
        addr    <= PADDR;
        wr_data <= PWDATA;
        is_wr_q <= PWRITE;
      end
      if (busy && ack_vld) PRDATA <= is_wr_q ? '0 : rd_data;
      else if (tmo_hit)    PRDATA <= '0;
    end
  end

  assign req_vld   = (state_q == ST_REQ);
  assign wr_en     = busy && is_wr_q;
  assign rd_en     = busy && !is_wr_q;
  assign PREADY    = (state_q == ST_RESP);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_apb2native_if.sv
// Testbench for reg_apb2native_if: table-driven directed transfers, reset
// corner cases and randomized transfers checked against a transaction model.
module tb_reg_apb2native_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          PCLK;
  logic          PRESETn;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;
  logic          req_vld, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          ack_vld;
  logic [DW-1:0] rd_data;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ready_cyc = 0;

  reg_apb2native_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .ack_vld(ack_vld), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: cycle (counted from the req_vld cycle as 0)
  // at which PREADY appears, given the ack delay in the same count.
  function automatic int model_k(input int dly);
`ifdef REG_APB2NATIVE_TIMEOUT_EN
    if (dly >= TO) return TO;
`endif
    return dly + 1;
  endfunction

  function automatic logic model_err(input int dly);
`ifdef REG_APB2NATIVE_TIMEOUT_EN
    return dly >= TO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] model_prdata(input logic w, input int dly,
                                                  input logic [DW-1:0] rdat);
    if (w || model_err(dly)) return '0;
    return rdat;
  endfunction

  // Drives one APB transfer starting at a negedge in an IDLE cycle, acks it
  // dly cycles after the req_vld cycle, and checks both sides of the bridge.
  // Returns at the negedge of the cycle after PREADY.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int dly, input logic [DW-1:0] rdat, input int exp_k,
                      input logic [DW-1:0] exp_prdata, input logic exp_err);
    int  k;
    bit  done;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    k = 0; done = 0;
    while (!done && k < 600) begin
      if (PREADY) begin
        chk("ready_cycle", 64'(k), 64'(exp_k));
        chk("prdata", PRDATA, exp_prdata);
        chk("pslverr", PSLVERR, exp_err);
        chk("en_in_resp", {wr_en, rd_en, req_vld}, 3'b000);
        last_ready_cyc = cyc;
        done = 1;
      end else begin
        chk("req_vld", req_vld, (k == 0));
        chk("wr_en", wr_en, w);
        chk("rd_en", rd_en, !w);
        chk("addr", addr, a);
        chk("wr_data", wr_data, d);
        chk("pslverr_low", PSLVERR, 1'b0);
        ack_vld = (k == dly);
        rd_data = (k == dly) ? rdat : $urandom;
        @(negedge PCLK);
        k++;
      end
    end
    if (!done) chk("ready_timeout", 64'(k), 64'(exp_k));
    PSEL = 1'b0; PENABLE = 1'b0; ack_vld = 1'b0;
    @(negedge PCLK);
    chk("ready_one_cycle", PREADY, 1'b0);
    chk("prdata_hold", PRDATA, exp_prdata);
  endtask

  // Stray ack while IDLE: nothing may change.
  task automatic stray_ack(input logic [DW-1:0] exp_prdata);
    ack_vld = 1'b1; rd_data = $urandom;
    @(negedge PCLK);
    ack_vld = 1'b0;
    chk("stray_pready", PREADY, 1'b0);
    chk("stray_prdata", PRDATA, exp_prdata);
    chk("stray_native", {req_vld, wr_en, rd_en}, 3'b000);
    chk("stray_state", dbg_state, 2'd0);
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dly;
    logic [DW-1:0] rdat;
    int            exp_k;
    logic [DW-1:0] exp_prdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdv, rrd;
    int            rdly, r1;

    vecs[0] = '{1'b1, 32'h10,       32'hA5A5A5A5, 0, 32'hFFFF0000, 1, 32'h0};
    vecs[1] = '{1'b0, 32'h20,       32'h0,        3, 32'h12345678, 4, 32'h12345678};
    vecs[2] = '{1'b0, 32'h0,        32'h0,        0, 32'h0000AAAA, 1, 32'h0000AAAA};
    vecs[3] = '{1'b0, 32'h4,        32'h0,        0, 32'h0000BBBB, 1, 32'h0000BBBB};
    vecs[4] = '{1'b1, 32'hFFFFFFFC, 32'h5A5A0F0F, 7, 32'h11111111, 8, 32'h0};
    vecs[5] = '{1'b0, 32'h100,      32'h0,        7, 32'hCAFEF00D, 8, 32'hCAFEF00D};

    // reset block
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    ack_vld = 0; rd_data = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_pready", PREADY, 1'b0);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_prdata", PRDATA, '0);
    chk("rst_native", {req_vld, wr_en, rd_en}, 3'b000);
    chk("rst_addr", addr, '0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_state", dbg_state, 2'd0);
    PRESETn = 1'b1;

    // directed table, back-to-back (first one starts right after reset release)
    r1 = 0;
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].dly, vecs[i].rdat,
           vecs[i].exp_k, vecs[i].exp_prdata, 1'b0);
      if (i == 3) chk("b2b_gap", 64'(last_ready_cyc - r1), 64'd3);
      r1 = last_ready_cyc;
    end

    // long ack delay: timeout in the optional build, indefinite wait otherwise
    xfer(1'b0, 32'h44, 32'h0, 300, 32'h87654321, model_k(300),
         model_prdata(1'b0, 300, 32'h87654321), model_err(300));
    stray_ack(model_prdata(1'b0, 300, 32'h87654321));
    stray_ack(model_prdata(1'b0, 300, 32'h87654321));

    // reset during WAIT of a write
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h30; PWDATA = 32'hDEADBEEF;
    @(negedge PCLK);
    PENABLE = 1;
    repeat (3) @(negedge PCLK);
    chk("pre_rst_wr_en", wr_en, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_pready", PREADY, 1'b0);
    chk("arst_native", {req_vld, wr_en, rd_en}, 3'b000);
    chk("arst_addr", addr, '0);
    chk("arst_wr_data", wr_data, '0);
    chk("arst_prdata", PRDATA, '0);
    chk("arst_pslverr", PSLVERR, 1'b0);
    PSEL = 0; PENABLE = 0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    stray_ack('0);
    xfer(1'b0, 32'h8, 32'h0, 1, 32'h0BADF00D, 2, 32'h0BADF00D, 1'b0);

    // randomized transfers against the transaction model
    for (int i = 0; i < 40; i++) begin
      rw   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rdv  = $urandom;
      rrd  = $urandom;
      rdly = $urandom_range(0, 12);
      xfer(rw, ra, rdv, rdly, rrd, model_k(rdly), model_prdata(rw, rdly, rrd),
           model_err(rdly));
      if ($urandom_range(0, 3) == 0) stray_ack(model_prdata(rw, rdly, rrd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_apb2native_if.md
REG_APB2NATIVE_IF -- requirements
Module: reg_apb2native_if

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, width of PADDR and addr.
REQ-002 SHALL have parameter DATA_WIDTH, 32, width of PWDATA, PRDATA, wr_data and rd_data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 255, number of cycles without ack before an error response (8-bit counter, range 1..255).
REQ-004 SHALL have port PCLK  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have APB completer ports: PSEL in 1; PENABLE in 1; PWRITE in 1; PADDR in ADDR_WIDTH; PWDATA in DATA_WIDTH; PREADY out 1; PRDATA out DATA_WIDTH; PSLVERR out 1.
REQ-007 SHALL have native initiator ports: req_vld out 1; wr_en out 1; rd_en out 1; addr out ADDR_WIDTH; wr_data out DATA_WIDTH; ack_vld in 1; rd_data in DATA_WIDTH.

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT and RESP.
REQ-009 IDLE: on PSEL=1 && PENABLE=0 (setup phase), SHALL register PADDR, PWRITE and PWDATA into addr, wr_en/rd_en and wr_data, then go to REQ; otherwise stay in IDLE.
REQ-010 REQ: SHALL assert req_vld=1 for exactly one cycle, with wr_en=PWRITE_latched and rd_en=!PWRITE_latched; on ack_vld the same cycle go to RESP, else go to WAIT.
REQ-011 WAIT: SHALL hold req_vld=0 and keep addr, wr_en, rd_en and wr_data stable; on ack_vld go to RESP.
REQ-012 On ack_vld in REQ or WAIT for a read, SHALL capture rd_data into PRDATA; for a write, SHALL set PRDATA=0.
REQ-013 RESP: SHALL assert PREADY=1 for exactly one cycle, then go to IDLE; PSLVERR is valid only while PREADY=1 and is 0 otherwise.
REQ-014 Minimum latency: setup phase at cycle T, ack in the REQ cycle gives PREADY=1 at cycle T+2.
REQ-015 SHALL hold PRDATA stable from RESP until the next capture.
REQ-016 SHALL ignore ack_vld in IDLE or RESP; the state and all outputs stay unchanged.
REQ-017 If PSEL drops during REQ or WAIT (protocol violation), SHALL complete the native transaction normally and still pulse PREADY once.
REQ-018 wr_en and rd_en SHALL be mutually exclusive and both 0 in IDLE and RESP.
REQ-019 Back-to-back transfers: a setup phase seen in the cycle after RESP SHALL be accepted without a bubble.

Reset
REQ-020 PRESETn low SHALL asynchronously force state=IDLE and PREADY=0, PSLVERR=0, PRDATA=0, req_vld=0, wr_en=0, rd_en=0, addr=0, wr_data=0, and clear the timeout counter.
REQ-021 Reset asserted mid-transaction SHALL abandon the transfer; a late ack_vld after reset release SHALL be ignored per REQ-016.
REQ-022 After PRESETn deasserts, the first setup phase SHALL be accepted on the first rising edge.

Configuration
REQ-023 Macro REG_APB2NATIVE_TIMEOUT_EN defined: an 8-bit counter SHALL count cycles in REQ and WAIT. When it reaches TIMEOUT_CYCLES without ack_vld, the block SHALL go to RESP with PSLVERR=1 and PRDATA=0, clear the counter, and ignore any later ack per REQ-016.
REQ-024 Macro REG_APB2NATIVE_TIMEOUT_EN undefined: the block SHALL have no counter, SHALL keep PSLVERR tied to 0, SHALL wait in WAIT indefinitely, and SHALL ignore TIMEOUT_CYCLES.
REQ-025 ack_vld in the same cycle the timeout is reached SHALL take priority, giving a normal response with PSLVERR=0.

Verification
REQ-026 Write PADDR=0x10, PWDATA=0xA5A5A5A5, ack in REQ cycle -> one req_vld pulse with wr_en=1, addr=0x10, wr_data=0xA5A5A5A5; PREADY at T+2; PSLVERR=0.
REQ-027 Read PADDR=0x20, ack 3 cycles after req_vld with rd_data=0x12345678 -> PRDATA=0x12345678 with PREADY; req_vld high for 1 cycle only.
REQ-028 Two back-to-back reads to 0x0 and 0x4, immediate acks -> two PREADY pulses 3 cycles apart; correct data for each read.
REQ-029 With REG_APB2NATIVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> PREADY=1, PSLVERR=1, PRDATA=0 eight cycles after REQ; a later stray ack changes nothing.
REQ-030 PRESETn pulsed low during WAIT of a write -> all outputs 0 immediately; a following read to 0x8 completes normally.
